// File: rtl/ex_result_stage.sv
// Execute-unit output stage: holds the flag register, evaluates branch conditions
// and hands bundles downstream through a registered-ready two-entry skid buffer.
module ex_result_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] result_i,
  input  logic             zero_flag_i,
  input  logic             pos_flag_i,
  input  logic             neg_flag_i,
  input  logic             overflow_flag_i,
  input  logic             set_flags_i,
  input  logic [2:0]       cond_i,
  input  logic [RD_W-1:0]  rd_i,
  input  logic             wr_en_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [RD_W-1:0]  rd_o,
  output logic             wr_en_o,
  output logic             taken_o,
  output logic [3:0]       flags_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   ready_reg;
  logic   [3:0] flags_reg;

  logic [WIDTH-1:0] main_result_reg, skid_result_reg;
  logic [RD_W-1:0]  main_rd_reg, skid_rd_reg;
  logic             main_wr_en_reg, skid_wr_en_reg;
  logic             main_taken_reg, skid_taken_reg;

  logic       acc, xfer;
  logic [3:0] in_flags, eff_flags;
  logic       taken_next;
  logic       load_main_in, load_main_skid, load_skid;

  assign valid_o  = (state_reg != EMPTY);
  assign ready_o  = ready_reg;
  assign acc      = valid_i & ready_reg & ~flush_i;
  assign xfer     = valid_o & ready_i;
  assign in_flags = {overflow_flag_i, neg_flag_i, pos_flag_i, zero_flag_i};

  // Condition is resolved against the flags this instruction itself produces, if any.
  always_comb begin
    eff_flags  = set_flags_i ? in_flags : flags_reg;
    taken_next = 1'b0;
    case (cond_i)
      3'd0: taken_next = 1'b1;
      3'd1: taken_next = eff_flags[0];
      3'd2: taken_next = ~eff_flags[0];
      3'd3: taken_next = eff_flags[1];
      3'd4: taken_next = eff_flags[2];
      3'd5: taken_next = eff_flags[3];
      3'd6: taken_next = ~eff_flags[3];
      default: taken_next = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (acc) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && xfer) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so no accept can race the skid-to-main move
        if (xfer) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush_i) begin
      state_next     = EMPTY;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b1;
      flags_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != FULL);
      if (acc && set_flags_i) begin
        flags_reg <= in_flags;
      end
    end
  end

  // Payload registers only change on a write into them; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_result_reg <= '0;
      main_rd_reg     <= '0;
      main_wr_en_reg  <= 1'b0;
      main_taken_reg  <= 1'b0;
      skid_result_reg <= '0;
      skid_rd_reg     <= '0;
      skid_wr_en_reg  <= 1'b0;
      skid_taken_reg  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_result_reg <= result_i;
        main_rd_reg     <= rd_i;
        main_wr_en_reg  <= wr_en_i;
        main_taken_reg  <= taken_next;
      end else if (load_main_skid) begin
        main_result_reg <= skid_result_reg;
        main_rd_reg     <= skid_rd_reg;
        main_wr_en_reg  <= skid_wr_en_reg;
        main_taken_reg  <= skid_taken_reg;
      end
      if (load_skid) begin
        skid_result_reg <= result_i;
        skid_rd_reg     <= rd_i;
        skid_wr_en_reg  <= wr_en_i;
        skid_taken_reg  <= taken_next;
      end
    end
  end

  assign result_o = main_result_reg;
  assign rd_o     = main_rd_reg;
  assign wr_en_o  = main_wr_en_reg;
  assign taken_o  = main_taken_reg;
  assign flags_o  = flags_reg;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed and randomised bench for ex_result_stage with a queue scoreboard
// and an occupancy model of the skid buffer.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] result_i = '0;
  logic        zero_flag_i = 1'b0, pos_flag_i = 1'b0, neg_flag_i = 1'b0, overflow_flag_i = 1'b0;
  logic        set_flags_i = 1'b0;
  logic [2:0]  cond_i = '0;
  logic [4:0]  rd_i = '0;
  logic        wr_en_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        wr_en_o;
  logic        taken_o;
  logic [3:0]  flags_o;

  ex_result_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .zero_flag_i(zero_flag_i), .pos_flag_i(pos_flag_i),
    .neg_flag_i(neg_flag_i), .overflow_flag_i(overflow_flag_i),
    .set_flags_i(set_flags_i), .cond_i(cond_i), .rd_i(rd_i), .wr_en_i(wr_en_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .rd_o(rd_o), .wr_en_o(wr_en_o), .taken_o(taken_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        tk;
  } ent_t;

  ent_t       sb[$];
  int         cnt = 0;
  logic [3:0] model_flags = 4'd0;
  int         checks = 0;
  int         failures = 0;

  function automatic logic eval_cond(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return ~f[0];
      3'd3: return f[1];
      3'd4: return f[2];
      3'd5: return f[3];
      3'd6: return ~f[3];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: check outputs, drive one cycle of inputs, update model.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [3:0] f4,
                       input logic sf, input logic [2:0] cond, input logic [4:0] rd,
                       input logic we, input logic fl, input logic rdy);
    logic m_valid, m_ready, acc, xfer;
    ent_t e;
    m_valid = (cnt != 0);
    m_ready = (cnt < 2);
    chk("valid_o", valid_o, m_valid);
    chk("ready_o", ready_o, m_ready);
    chk("flags_o", flags_o, model_flags);
    if (m_valid) begin
      e = sb[0];
      chk("result_o", result_o, e.res);
      chk("rd_o", rd_o, e.rd);
      chk("wr_en_o", wr_en_o, e.we);
      chk("taken_o", taken_o, e.tk);
    end
    valid_i = v; result_i = res;
    {overflow_flag_i, neg_flag_i, pos_flag_i, zero_flag_i} = f4;
    set_flags_i = sf; cond_i = cond; rd_i = rd; wr_en_i = we;
    flush_i = fl; ready_i = rdy;
    acc  = v & m_ready & ~fl;
    xfer = m_valid & rdy;
    if (xfer) e = sb.pop_front();
    if (fl) sb.delete();
    if (acc) begin
      sb.push_back('{res, rd, we, eval_cond(cond, sf ? f4 : model_flags)});
      if (sf) model_flags = f4;
    end
    cnt = fl ? 0 : cnt - int'(xfer) + int'(acc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete(); cnt = 0; model_flags = 4'd0;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_ready_o", ready_o, 1'b1);
    chk("rst_result_o", result_o, 32'h0);
    chk("rst_rd_o", rd_o, 5'd0);
    chk("rst_wr_en_o", wr_en_o, 1'b0);
    chk("rst_taken_o", taken_o, 1'b0);
    chk("rst_flags_o", flags_o, 4'h0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Stream three flag-setting bundles at full rate
    cycle(1'b1, 32'd5,        4'b0100, 1'b1, 3'd3, 5'd1, 1'b1, 1'b0, 1'b1);
    chk("stream_flags_a", flags_o, 4'b0100);
    cycle(1'b1, 32'd0,        4'b0101, 1'b1, 3'd1, 5'd2, 1'b1, 1'b0, 1'b1);
    chk("stream_flags_b", flags_o, 4'b0101);
    cycle(1'b1, 32'hFFFFFFFF, 4'b1010, 1'b1, 3'd5, 5'd3, 1'b0, 1'b0, 1'b1);
    chk("stream_flags_c", flags_o, 4'b1010);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: two captured, then ready_o drops
    cycle(1'b1, 32'hA1, 4'h0, 1'b0, 3'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA2, 4'h0, 1'b0, 3'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("bp_ready_low", ready_o, 1'b0);
    cycle(1'b1, 32'hA3, 4'h0, 1'b0, 3'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA4, 4'h0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("bp_held_result", result_o, 32'hA1);
    idle(1'b1);
    chk("bp_drain_second", result_o, 32'hA2);
    idle(1'b1);
    idle(1'b1);

    // Condition evaluated against stored flags vs. own flags
    cycle(1'b1, 32'h0, 4'b0001, 1'b1, 3'd0, 5'd8, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h7, 4'b0010, 1'b0, 3'd1, 5'd9, 1'b0, 1'b0, 1'b1);
    chk("eq_stored_taken", taken_o, 1'b1);
    cycle(1'b1, 32'h7, 4'b0010, 1'b0, 3'd2, 5'd9, 1'b0, 1'b0, 1'b1);
    chk("ne_stored_taken", taken_o, 1'b0);
    cycle(1'b1, 32'h7, 4'b0010, 1'b1, 3'd1, 5'd9, 1'b0, 1'b0, 1'b1);
    chk("eq_own_taken", taken_o, 1'b0);
    idle(1'b1);

    // Flush while FULL with a bundle offered
    cycle(1'b1, 32'hB1, 4'h0, 1'b0, 3'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB2, 4'h0, 1'b0, 3'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD, 4'hF, 1'b1, 3'd0, 5'd12, 1'b1, 1'b1, 1'b0);
    chk("flush_valid_o", valid_o, 1'b0);
    chk("flush_ready_o", ready_o, 1'b1);
    chk("flush_flags_kept", flags_o, 4'b0010);
    idle(1'b1);
    cycle(1'b1, 32'hC1, 4'h0, 1'b0, 3'd0, 5'd13, 1'b1, 1'b0, 1'b1);
    chk("post_flush_result", result_o, 32'hC1);
    idle(1'b1);

    // Reset mid-stream while FULL
    cycle(1'b1, 32'hD1, 4'b1000, 1'b1, 3'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hD2, 4'b0100, 1'b1, 3'd0, 5'd15, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 1'($urandom),
            3'($urandom), 5'($urandom), 1'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
